// File: rtl/xnor_share_arbiter.sv
// xnor_share_arbiter
//   Shares one SLICE-bit XNOR engine between NREQ requesters. A round-robin
//   arbiter accepts one operand pair at a time. The pair is XNORed LSB-first,
//   SLICE bits per cycle, and the result is returned on a single response port
//   tagged with the requester id.
//
//   Optional feature: define XNOR_SHARE_POPCOUNT_EN to add rsp_ones, the count
//   of equal bit positions, accumulated one slice per RUN cycle.
//
// Handshakes:
//   A request i transfers on a rising edge where req_valid[i] && req_ready[i].
//   A response transfers on a rising edge where rsp_valid && rsp_ready. While
//   rsp_valid is high, rsp_id/rsp_xnor/rsp_match(/rsp_ones) are held stable.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   req_valid[i]   : requester i has an operand pair on req_a/req_b
//   req_a, req_b   : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready      : one-hot accept strobe, only in IDLE
//   rsp_valid      : result available (DONE state)
//   rsp_ready      : consumer accepts result
//   rsp_id         : requester index of the result
//   rsp_xnor       : ~(a ^ b)
//   rsp_match      : a == b
//   rsp_ones       : popcount of rsp_xnor (XNOR_SHARE_POPCOUNT_EN only)
//   busy           : FSM is in RUN or DONE
module xnor_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_xnor,
  output logic                    rsp_match,
`ifdef XNOR_SHARE_POPCOUNT_EN
  output logic [$clog2(WIDTH+1)-1:0] rsp_ones,
`endif
  output logic                    busy
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               match_q, match_d;
  logic [SLICE-1:0]   slice_x;
  logic [IDW-1:0]     cand;
  logic [IDW-1:0]     grant_idx;
  logic               grant_found;
`ifdef XNOR_SHARE_POPCOUNT_EN
  localparam int OW = $clog2(WIDTH+1);
  logic [OW-1:0]      ones_q, ones_d;
`endif

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_grant_q) + i) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    match_d      = match_q;
    req_ready    = '0;
    slice_x      = ~(a_q[cnt_q*SLICE +: SLICE] ^ b_q[cnt_q*SLICE +: SLICE]);
`ifdef XNOR_SHARE_POPCOUNT_EN
    ones_d       = ones_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          a_d          = req_a[grant_idx*WIDTH +: WIDTH];
          b_d          = req_b[grant_idx*WIDTH +: WIDTH];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          cnt_d        = '0;
`ifdef XNOR_SHARE_POPCOUNT_EN
          ones_d       = '0;
`endif
          state_d      = RUN;
        end
      end
      RUN: begin
        result_d[cnt_q*SLICE +: SLICE] = slice_x;
`ifdef XNOR_SHARE_POPCOUNT_EN
        ones_d = ones_q + OW'($countones(slice_x));
`endif
        if (cnt_q == CW'(NSL - 1)) begin
          // Match uses the vector including the slice written this cycle.
          match_d = &result_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
      match_q      <= 1'b0;
`ifdef XNOR_SHARE_POPCOUNT_EN
      ones_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
      match_q      <= match_d;
`ifdef XNOR_SHARE_POPCOUNT_EN
      ones_q       <= ones_d;
`endif
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_xnor  = result_q;
  assign rsp_match = match_q;
`ifdef XNOR_SHARE_POPCOUNT_EN
  assign rsp_ones  = ones_q;
`endif

endmodule

// File: doc/xnor_share_arbiter.md
Name: xnor_share_arbiter

Overview:
- Shares one SLICE-bit XNOR engine between NREQ requesters.
- Each requester submits a WIDTH-bit operand pair and receives the bitwise XNOR vector plus an all-bits-equal flag.
- A round-robin arbiter grants one request at a time. The FSM feeds the operands through the engine over WIDTH/SLICE cycles, then returns the result on a single valid/ready response port tagged with the requester id.
- Sits between the compare clients and the shared XNOR datapath.

Parameters:
- NREQ, 4: number of requesters (>=1).
- WIDTH, 16: operand width in bits.
- SLICE, 4: bits XNORed per RUN cycle. WIDTH must be an integer multiple of SLICE.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- req_valid, input, NREQ: per-requester request valid.
- req_a, input, NREQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b, input, NREQ*WIDTH: operand B; same packing as req_a.
- req_ready, output, NREQ: one-hot grant/accept strobe.
- rsp_valid, output, 1: result valid.
- rsp_ready, input, 1: consumer accepts result.
- rsp_id, output, max(1,$clog2(NREQ)): index of the requester the result belongs to.
- rsp_xnor, output, WIDTH: bitwise ~(a^b) of the granted operands.
- rsp_match, output, 1: 1 when a==b (rsp_xnor all ones).
- busy, output, 1: high in RUN or DONE.

Behaviour:
- Reset values:
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_xnor=0, rsp_match=0, busy=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any req_valid is high, pick g = first set req_valid searching last_grant+1, +2, ... modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle only. At most one req_ready bit is ever high; req_ready is 0 outside IDLE.
  - On the edge: latch a, b and g; set slice counter=0; last_grant<=g; go to RUN.
  - If no req_valid is high, stay in IDLE.
- RUN:
  - Each cycle, XNOR slice k = bits [k*SLICE +: SLICE] of the latched a and b, and write it into result bits [k*SLICE +: SLICE]. Slices run LSB-first.
  - After slice WIDTH/SLICE-1 is written, go to DONE.
  - rsp_match is computed as the AND of all result bits when entering DONE.
  - Requester inputs are ignored in RUN; operands are already captured.
- DONE:
  - rsp_valid=1; rsp_id, rsp_xnor and rsp_match hold stable until handshake.
  - On rsp_valid && rsp_ready: go to IDLE; rsp_valid=0 next cycle.
  - If rsp_ready is already high on DONE entry, the handshake completes in that first DONE cycle.
- Latency:
  - Accept at cycle T; rsp_valid first high at T+1+WIDTH/SLICE.
  - Minimum issue interval is WIDTH/SLICE+2 cycles (accept, RUN cycles, DONE with rsp_ready high, back to IDLE accept).
- Fairness: a requester holding req_valid continuously is granted within NREQ grants.
- Boundary conditions:
  - SLICE==WIDTH: exactly one RUN cycle.
  - NREQ==1: rsp_id is constant 0.
  - A requester dropping req_valid before it is granted is simply not served; there is no penalty.
  - Reset asserted in any state overrides everything. The in-flight transaction is discarded with no response, and the pointer returns to NREQ-1.
  - rsp_ready held low keeps DONE indefinitely; no new requests are accepted meanwhile.

Optional Feature:
- Macro: XNOR_SHARE_POPCOUNT_EN.
- When defined:
  - Extra output rsp_ones, width $clog2(WIDTH+1): number of equal bit positions (popcount of rsp_xnor).
  - Accumulated per RUN slice; reset value 0; valid and stable with rsp_valid.
  - Latency unchanged.
- When undefined: port and accumulator are absent; all other behaviour is identical.

Test Plan:
- Defaults. After reset, requester 0 only: a=0x1234, b=0x1234 -> req_ready[0] for 1 cycle; rsp_valid 5 cycles later; rsp_id=0, rsp_xnor=0xFFFF, rsp_match=1 (rsp_ones=16 if enabled).
- Requester 2 only: a=0x00FF, b=0x0F0F -> rsp_id=2, rsp_xnor=0xF00F, rsp_match=0 (rsp_ones=8).
- All four requesters valid continuously after reset, rsp_ready=1 -> grant order 0,1,2,3,0; each response id matches; grants spaced 6 cycles apart.
- Hold rsp_ready=0 for 10 cycles in DONE with requests pending -> rsp outputs stable, req_ready stays 0, busy=1. Then rsp_ready=1 -> next grant goes to the next requester in round-robin order.
- Assert reset during RUN of slice 2 -> no rsp_valid ever appears for that request; all outputs 0 next cycle. A new request from requester 1 is then granted ahead of requester 3 (pointer reset).
- Instantiate with SLICE=16, NREQ=1: a=0xAAAA, b=0x5555 -> rsp_valid 2 cycles after accept, rsp_xnor=0x0000, rsp_match=0, rsp_id=0.
